// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the 27x15 sequential multiplier.
// Imported by the multiplier top and its shift-add step.
package mult_pkg;

  localparam int MCAND_W  = 27;
  localparam int MPLIER_W = 15;
  localparam int PROD_W   = MCAND_W + MPLIER_W;
  localparam int CNT_W    = $clog2(MPLIER_W);
  // Upper partial-sum width: one guard bit above the multiplicand.
  localparam int HI_W     = MCAND_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mult_shift_add_step.sv
// One radix-2 iteration: conditional add of mcand into hi, then shift
// {carry,hi,lo} right by one. Ports: hi/lo partial sum in, mcand, add bit; hi/lo out.
module mult_shift_add_step
  import mult_pkg::*;
(
  input  logic [HI_W-1:0]     hi_i,
  input  logic [MPLIER_W-2:0] lo_top_i,
  input  logic [MCAND_W-1:0]  mcand_i,
  input  logic                add_i,
  output logic [HI_W-1:0]     hi_o,
  output logic [MPLIER_W-1:0] lo_o
);

  logic [HI_W:0] sum;

  always_comb begin
    sum = {1'b0, hi_i};
    if (add_i) begin
      sum = sum + {2'b00, mcand_i};
    end
    hi_o = sum[HI_W:1];
    // lo[0] is the bit shifted out; the new MSB of lo is sum[0].
    lo_o = {sum[0], lo_top_i};
  end

endmodule

// File: rtl/seq_mult_27x15.sv
// Sequential unsigned 27x15 shift-add multiplier, one multiplier bit per cycle.
// in_valid/in_ready take mcand/mplier/addend; out_valid/out_ready return product/addend_out.
module seq_mult_27x15
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MCAND_W-1:0]  mcand,
  input  logic [MPLIER_W-1:0] mplier,
  input  logic [MPLIER_W-1:0] addend,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   product,
  output logic [MPLIER_W-1:0] addend_out
);

  state_e              state_q, state_d;
  logic [MCAND_W-1:0]  mcand_q, mcand_d;
  logic [MPLIER_W-1:0] mpl_q, mpl_d;
  logic [MPLIER_W-1:0] add_q, add_d;
  logic [HI_W-1:0]     hi_q, hi_d;
  logic [MPLIER_W-1:0] lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [MPLIER_W-1:0] aout_q, aout_d;

  logic [HI_W-1:0]     step_hi;
  logic [MPLIER_W-1:0] step_lo;

  mult_shift_add_step u_step (
    .hi_i     (hi_q),
    .lo_top_i (lo_q[MPLIER_W-1:1]),
    .mcand_i  (mcand_q),
    .add_i    (mpl_q[0]),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mpl_q   <= '0;
      add_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      aout_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mpl_q   <= mpl_d;
      add_q   <= add_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      aout_q  <= aout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mpl_d   = mpl_q;
    add_d   = add_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    aout_d  = aout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          mcand_d = mcand;
          mpl_d   = mplier;
          add_d   = addend;
          hi_d    = '0;
          lo_d    = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        mpl_d = mpl_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MPLIER_W - 1)) begin
          state_d = DONE;
          // Output registers only load here so they hold across IDLE/BUSY.
          prod_d  = {step_hi[MCAND_W-1:0], step_lo};
          aout_d  = add_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign product    = prod_q;
  assign addend_out = aout_q;

  // hi stays below 2^27 because hi < 2^27 and mcand < 2^27 before each shift.
  a_no_carry: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == BUSY) |-> (step_hi[HI_W-1] == 1'b0)
  );

endmodule

// File: tb/tb_seq_mult_27x15.sv
// Self-checking bench for seq_mult_27x15: vector table, backpressure,
// busy-time noise, mid-BUSY reset and a random back-to-back stream.
module tb_seq_mult_27x15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] mcand;
  logic [14:0] mplier;
  logic [14:0] addend;
  logic        out_valid;
  logic        out_ready;
  logic [41:0] product;
  logic [14:0] addend_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_27x15 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mcand      (mcand),
    .mplier     (mplier),
    .addend     (addend),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .addend_out (addend_out)
  );

  typedef struct {
    logic [26:0] mc;
    logic [14:0] mp;
    logic [14:0] ad;
    logic [41:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Accept one operand set, wait for out_valid. With noisy=1, in_valid stays
  // high with random operands while busy. lat is the edge count from the
  // accept edge to the first edge that samples out_valid high.
  task automatic run_txn(input logic [26:0] mc, input logic [14:0] mp,
                         input logic [14:0] ad, input bit noisy,
                         output logic [41:0] p, output logic [14:0] a,
                         output int lat, output int busy_rdy);
    int n;
    int k;
    in_valid = 1'b1;
    mcand = mc;
    mplier = mp;
    addend = ad;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) timeout("accept");
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    in_valid = noisy;
    k = 0;
    busy_rdy = 0;
    while (!out_valid && k < 100) begin
      if (noisy) begin
        mcand = 27'($urandom);
        mplier = 15'($urandom);
        addend = 15'($urandom);
      end
      @(posedge clk); #1; k++;
      if (in_ready) busy_rdy++;
    end
    if (!out_valid) timeout("out_valid");
    in_valid = 1'b0;
    lat = k + 1;
    p = product;
    a = addend_out;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[10];

  initial begin
    logic [41:0] p;
    logic [14:0] a;
    int lat;
    int br;
    int bad;
    int prev_acc;
    logic [63:0] gold;

    vecs[0] = '{27'h7FF_FFFF, 15'h7FFF, 15'h0001, 42'h3FF_F7FF_8001};
    vecs[1] = '{27'h000_0005, 15'h0003, 15'h0000, 42'h00F};
    vecs[2] = '{27'h000_0005, 15'h0000, 15'h1234, 42'h0};
    vecs[3] = '{27'h000_0000, 15'h7FFF, 15'h7FFF, 42'h0};
    vecs[4] = '{27'h123_4567, 15'h0ABC, 15'h0042, 42'd52455865764};
    vecs[5] = '{27'h000_0001, 15'h0001, 15'h7FFF, 42'h1};
    vecs[6] = '{27'h7FF_FFFF, 15'h0001, 15'h0100, 42'h7FF_FFFF};
    vecs[7] = '{27'h000_0001, 15'h4000, 15'h0002, 42'h4000};
    vecs[8] = '{27'h000_0002, 15'h7FFF, 15'h0003, 42'hFFFE};
    vecs[9] = '{27'h400_0000, 15'h4000, 15'h5555, 42'h100_0000_0000};

    rst = 1'b1;
    in_valid = 1'b0;
    mcand = '0;
    mplier = '0;
    addend = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_addend_out", 64'(addend_out), 64'd0);
    rst = 1'b0;

    // Table-driven vectors, out_ready held high.
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].mc, vecs[i].mp, vecs[i].ad, 1'b0, p, a, lat, br);
      chk($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_addend", i), 64'(a), 64'(vecs[i].ad));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd16);
      chk($sformatf("vec%0d_busy_ready", i), 64'(br), 64'd0);
    end
    #1;
    chk("idle_after_hs_out_valid", 64'(out_valid), 64'd0);
    chk("idle_after_hs_in_ready", 64'(in_ready), 64'd1);

    // Backpressure: hold out_ready low 20 cycles after out_valid.
    out_ready = 1'b0;
    run_txn(27'h0AB_CDEF, 15'h1357, 15'h2468, 1'b0, p, a, lat, br);
    chk("bp_product", 64'(p), 64'd11259375 * 64'd4951);
    chk("bp_addend", 64'(a), 64'h2468);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      mcand = 27'($urandom);
      @(posedge clk); #1;
      if (product !== p || addend_out !== a || in_ready !== 1'b0
          || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    chk("bp_hold_violations", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_product", 64'(product), 64'(p));

    // in_valid high with changing operands during BUSY.
    run_txn(27'h3C3_C3C3, 15'h5A5A, 15'h0F0F, 1'b1, p, a, lat, br);
    chk("noisy_product", 64'(p), 64'd63161283 * 64'd23130);
    chk("noisy_addend", 64'(a), 64'h0F0F);
    chk("noisy_busy_ready", 64'(br), 64'd0);
    chk("noisy_latency", 64'(lat), 64'd16);

    // Reset during the 7th BUSY cycle.
    in_valid = 1'b1;
    mcand = 27'h555_5555;
    mplier = 15'h7777;
    addend = 15'h1111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_product", 64'(product), 64'd0);
    chk("midrst_addend", 64'(addend_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn(27'h123_4567, 15'h0ABC, 15'h0007, 1'b0, p, a, lat, br);
    chk("postrst_product", 64'(p), 64'd52455865764);
    chk("postrst_addend", 64'(a), 64'h7);
    chk("postrst_latency", 64'(lat), 64'd16);

    // Random back-to-back stream through a modelled adder stage.
    bad = 0;
    prev_acc = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [26:0] mc;
      logic [14:0] mp;
      logic [14:0] ad;
      mc = 27'($urandom);
      mp = 15'($urandom);
      ad = 15'($urandom);
      if (i % 50 == 0) mc = 27'h7FF_FFFF;
      if (i % 70 == 0) mp = 15'h0;
      gold = 64'(mc) * 64'(mp);
      run_txn(mc, mp, ad, 1'b0, p, a, lat, br);
      if (64'(p) !== gold || a !== ad
          || 64'(p) + 64'(a) !== gold + 64'(ad)) begin
        bad++;
        if (bad < 5)
          $display("FAIL rand%0d: got p=0x%0h a=0x%0h expected p=0x%0h a=0x%0h",
                   i, p, a, gold, ad);
      end
      if (i > 0 && acc_cyc - prev_acc != 17) bad++;
      prev_acc = acc_cyc;
    end
    chk("random_stream_bad", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
